triangle_setup: RTL and testbench

- Pipelined triangle-setup engine. Successor to the single-triangle edge-coefficient stage.
- Accepts one triangle per cycle over a valid/ready handshake and computes three edge equations E_i(x,y) = A_i*x + B_i*y + C_i, the doubled signed area, and a screen-clipped bounding box.
- Applies winding normalisation, back/front-face culling, degenerate rejection and off-screen rejection, and keeps statistics counters.
- Sits between vertex fetch/transform and the rasteriser's pixel walker.

---
 rtl/triangle_setup.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_triangle_setup.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_setup.sv
// Pipelined triangle setup: edge coefficients, doubled area, clipped bbox,
// winding normalisation, cull/degenerate/offscreen rejection and statistics.
// Three compute stages (s1..s3) feed a final output register; the whole pipe
// freezes while a valid result is waiting on the downstream.
module triangle_setup #(
  parameter int COORD_WIDTH   = 16,
  parameter int COEF_WIDTH    = 2*COORD_WIDTH+3,
  parameter int SCREEN_X_SIZE = 800,
  parameter int SCREEN_Y_SIZE = 600,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [2:0][1:0][COORD_WIDTH-1:0]        vertexes,
  input  logic [1:0]                              cull_mode,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [2:0][COORD_WIDTH:0]               edge_a,
  output logic [2:0][COORD_WIDTH:0]               edge_b,
  output logic [2:0][COEF_WIDTH-1:0]              edge_c,
  output logic [COEF_WIDTH-1:0]                   area2,
  output logic [COORD_WIDTH-1:0]                  bbox_xmin,
  output logic [COORD_WIDTH-1:0]                  bbox_xmax,
  output logic [COORD_WIDTH-1:0]                  bbox_ymin,
  output logic [COORD_WIDTH-1:0]                  bbox_ymax,
  input  logic                                    stats_clr,
  output logic [CNT_WIDTH-1:0]                    cnt_in,
  output logic [CNT_WIDTH-1:0]                    cnt_out,
  output logic [CNT_WIDTH-1:0]                    cnt_culled,
  output logic                                    idle
);

  localparam int CW = COORD_WIDTH;
  localparam int AW = COORD_WIDTH + 1;
  localparam int PW = 2 * COORD_WIDTH;

  typedef logic signed [CW-1:0]         coord_t;
  typedef logic signed [AW-1:0]         ab_t;
  typedef logic signed [PW-1:0]         prod_t;
  typedef logic signed [COEF_WIDTH-1:0] coef_t;

  localparam coord_t X_LIM = coord_t'(SCREEN_X_SIZE - 1);
  localparam coord_t Y_LIM = coord_t'(SCREEN_Y_SIZE - 1);

  // Clamp a signed coordinate into [0, lim]
  function automatic coord_t clip(input coord_t v, input coord_t lim);
    if (v[CW-1])     return '0;
    else if (v > lim) return lim;
    else             return v;
  endfunction

  logic stall;
  logic out_valid_q;

  assign stall     = out_valid_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = out_valid_q;

  // ---------------- stage 1: raw vertex capture ----------------
  logic      s1_valid_q;
  coord_t    s1_x_q [3];
  coord_t    s1_y_q [3];
  logic [1:0] s1_cull_q;

  // Capture the incoming triangle; a cycle without in_valid becomes a bubble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_cull_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        s1_x_q[i] <= '0;
        s1_y_q[i] <= '0;
      end
    end else if (!stall) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_cull_q <= cull_mode;
        for (int i = 0; i < 3; i++) begin
          s1_x_q[i] <= $signed(vertexes[i][0]);
          s1_y_q[i] <= $signed(vertexes[i][1]);
        end
      end
    end
  end

  coord_t s1_xn [3];
  coord_t s1_yn [3];
  ab_t    a_d [3];
  ab_t    b_d [3];
  coord_t xmin_d, xmax_d, ymin_d, ymax_d;

  // A/B edge terms (vertex i against its successor) and raw extents
  always_comb begin
    s1_xn[0] = s1_x_q[1];
    s1_xn[1] = s1_x_q[2];
    s1_xn[2] = s1_x_q[0];
    s1_yn[0] = s1_y_q[1];
    s1_yn[1] = s1_y_q[2];
    s1_yn[2] = s1_y_q[0];
    xmin_d = s1_x_q[0];
    xmax_d = s1_x_q[0];
    ymin_d = s1_y_q[0];
    ymax_d = s1_y_q[0];
    for (int i = 0; i < 3; i++) begin
      a_d[i] = ab_t'(s1_y_q[i]) - ab_t'(s1_yn[i]);
      b_d[i] = ab_t'(s1_xn[i]) - ab_t'(s1_x_q[i]);
      if (s1_x_q[i] < xmin_d) xmin_d = s1_x_q[i];
      if (s1_x_q[i] > xmax_d) xmax_d = s1_x_q[i];
      if (s1_y_q[i] < ymin_d) ymin_d = s1_y_q[i];
      if (s1_y_q[i] > ymax_d) ymax_d = s1_y_q[i];
    end
  end

  // ---------------- stage 2: A/B/extents registered ----------------
  logic       s2_valid_q;
  coord_t     s2_x_q [3];
  coord_t     s2_y_q [3];
  ab_t        s2_a_q [3];
  ab_t        s2_b_q [3];
  coord_t     s2_xmin_q, s2_xmax_q, s2_ymin_q, s2_ymax_q;
  logic [1:0] s2_cull_q;

  // Advance stage 1 results
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_q <= 1'b0;
      s2_cull_q  <= '0;
      s2_xmin_q  <= '0;
      s2_xmax_q  <= '0;
      s2_ymin_q  <= '0;
      s2_ymax_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        s2_x_q[i] <= '0;
        s2_y_q[i] <= '0;
        s2_a_q[i] <= '0;
        s2_b_q[i] <= '0;
      end
    end else if (!stall) begin
      s2_valid_q <= s1_valid_q;
      s2_cull_q  <= s1_cull_q;
      s2_xmin_q  <= xmin_d;
      s2_xmax_q  <= xmax_d;
      s2_ymin_q  <= ymin_d;
      s2_ymax_q  <= ymax_d;
      for (int i = 0; i < 3; i++) begin
        s2_x_q[i] <= s1_x_q[i];
        s2_y_q[i] <= s1_y_q[i];
        s2_a_q[i] <= a_d[i];
        s2_b_q[i] <= b_d[i];
      end
    end
  end

  coord_t s2_xn [3];
  coord_t s2_yn [3];
  prod_t  p_lo [3];
  prod_t  p_hi [3];
  coef_t  c_d [3];

  // C_i = x_i*y_j - x_j*y_i, widened before the subtraction so it cannot wrap
  always_comb begin
    s2_xn[0] = s2_x_q[1];
    s2_xn[1] = s2_x_q[2];
    s2_xn[2] = s2_x_q[0];
    s2_yn[0] = s2_y_q[1];
    s2_yn[1] = s2_y_q[2];
    s2_yn[2] = s2_y_q[0];
    for (int i = 0; i < 3; i++) begin
      p_lo[i] = prod_t'(s2_x_q[i]) * prod_t'(s2_yn[i]);
      p_hi[i] = prod_t'(s2_xn[i]) * prod_t'(s2_y_q[i]);
      c_d[i]  = coef_t'(p_lo[i]) - coef_t'(p_hi[i]);
    end
  end

  // ---------------- stage 3: C registered ----------------
  logic       s3_valid_q;
  ab_t        s3_a_q [3];
  ab_t        s3_b_q [3];
  coef_t      s3_c_q [3];
  coord_t     s3_xmin_q, s3_xmax_q, s3_ymin_q, s3_ymax_q;
  logic [1:0] s3_cull_q;

  // Advance stage 2 results
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s3_valid_q <= 1'b0;
      s3_cull_q  <= '0;
      s3_xmin_q  <= '0;
      s3_xmax_q  <= '0;
      s3_ymin_q  <= '0;
      s3_ymax_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        s3_a_q[i] <= '0;
        s3_b_q[i] <= '0;
        s3_c_q[i] <= '0;
      end
    end else if (!stall) begin
      s3_valid_q <= s2_valid_q;
      s3_cull_q  <= s2_cull_q;
      s3_xmin_q  <= s2_xmin_q;
      s3_xmax_q  <= s2_xmax_q;
      s3_ymin_q  <= s2_ymin_q;
      s3_ymax_q  <= s2_ymax_q;
      for (int i = 0; i < 3; i++) begin
        s3_a_q[i] <= s2_a_q[i];
        s3_b_q[i] <= s2_b_q[i];
        s3_c_q[i] <= c_d[i];
      end
    end
  end

  coef_t area_raw;
  logic  area_neg, area_zero, face_cull, offscreen, reject;
  ab_t   oa_d [3];
  ab_t   ob_d [3];
  coef_t oc_d [3];
  coef_t oarea_d;

  // Area, rejection and winding normalisation so inside always means E_i > 0
  always_comb begin
    area_raw  = s3_c_q[0] + s3_c_q[1] + s3_c_q[2];
    area_neg  = area_raw[COEF_WIDTH-1];
    area_zero = (area_raw == '0);
    face_cull = ((s3_cull_q == 2'd1) && area_neg) ||
                ((s3_cull_q == 2'd2) && !area_neg && !area_zero);
    offscreen = s3_xmax_q[CW-1] || (s3_xmin_q > X_LIM) ||
                s3_ymax_q[CW-1] || (s3_ymin_q > Y_LIM);
    reject    = area_zero | face_cull | offscreen;
    oarea_d   = area_neg ? -area_raw : area_raw;
    for (int i = 0; i < 3; i++) begin
      oa_d[i] = area_neg ? -s3_a_q[i] : s3_a_q[i];
      ob_d[i] = area_neg ? -s3_b_q[i] : s3_b_q[i];
      oc_d[i] = area_neg ? -s3_c_q[i] : s3_c_q[i];
    end
  end

  // ---------------- output register ----------------
  logic [2:0][AW-1:0]         edge_a_q, edge_b_q;
  logic [2:0][COEF_WIDTH-1:0] edge_c_q;
  logic [COEF_WIDTH-1:0]      area2_q;
  logic [CW-1:0]              xmin_q, xmax_q, ymin_q, ymax_q;

  // Rejected triangles leave a bubble; data only changes on a surviving result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      edge_a_q    <= '0;
      edge_b_q    <= '0;
      edge_c_q    <= '0;
      area2_q     <= '0;
      xmin_q      <= '0;
      xmax_q      <= '0;
      ymin_q      <= '0;
      ymax_q      <= '0;
    end else if (!stall) begin
      out_valid_q <= s3_valid_q & ~reject;
      if (s3_valid_q && !reject) begin
        for (int i = 0; i < 3; i++) begin
          edge_a_q[i] <= oa_d[i];
          edge_b_q[i] <= ob_d[i];
          edge_c_q[i] <= oc_d[i];
        end
        area2_q <= oarea_d;
        xmin_q  <= clip(s3_xmin_q, X_LIM);
        xmax_q  <= clip(s3_xmax_q, X_LIM);
        ymin_q  <= clip(s3_ymin_q, Y_LIM);
        ymax_q  <= clip(s3_ymax_q, Y_LIM);
      end
    end
  end

  assign edge_a    = edge_a_q;
  assign edge_b    = edge_b_q;
  assign edge_c    = edge_c_q;
  assign area2     = area2_q;
  assign bbox_xmin = xmin_q;
  assign bbox_xmax = xmax_q;
  assign bbox_ymin = ymin_q;
  assign bbox_ymax = ymax_q;

  // ---------------- statistics ----------------
  logic [CNT_WIDTH-1:0] cnt_in_q, cnt_out_q, cnt_culled_q;

  // Wrapping event counters; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_in_q     <= '0;
      cnt_out_q    <= '0;
      cnt_culled_q <= '0;
    end else begin
      if (stats_clr)              cnt_in_q <= '0;
      else if (in_valid && !stall) cnt_in_q <= cnt_in_q + CNT_WIDTH'(1);
      if (stats_clr)                  cnt_out_q <= '0;
      else if (out_valid_q && out_ready) cnt_out_q <= cnt_out_q + CNT_WIDTH'(1);
      if (stats_clr)                          cnt_culled_q <= '0;
      else if (s3_valid_q && reject && !stall) cnt_culled_q <= cnt_culled_q + CNT_WIDTH'(1);
    end
  end

  assign cnt_in     = cnt_in_q;
  assign cnt_out    = cnt_out_q;
  assign cnt_culled = cnt_culled_q;
  assign idle       = ~(s1_valid_q | s2_valid_q | s3_valid_q | out_valid_q);

endmodule

// File: tb/tb_triangle_setup.sv
// Directed bench for triangle_setup: latency, edge math, winding flip, culling,
// clipping, stall behaviour, counters and reset flush.
module tb_triangle_setup;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [2:0][1:0][15:0]    vertexes = '0;
  logic [1:0]               cull_mode = 2'd0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic [2:0][16:0]         edge_a, edge_b;
  logic [2:0][34:0]         edge_c;
  logic [34:0]              area2;
  logic [15:0]              bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
  logic                     stats_clr = 1'b0;
  logic [15:0]              cnt_in, cnt_out, cnt_culled;
  logic                     idle;

  int errors = 0;
  int checks = 0;
  int exp_in = 0, exp_out = 0, exp_cull = 0;

  triangle_setup dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .vertexes(vertexes), .cull_mode(cull_mode), .out_valid(out_valid),
    .out_ready(out_ready), .edge_a(edge_a), .edge_b(edge_b), .edge_c(edge_c),
    .area2(area2), .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax),
    .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax), .stats_clr(stats_clr),
    .cnt_in(cnt_in), .cnt_out(cnt_out), .cnt_culled(cnt_culled), .idle(idle)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_tri(input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2, input logic [1:0] cm);
    vertexes[0][0] = 16'(x0);
    vertexes[0][1] = 16'(y0);
    vertexes[1][0] = 16'(x1);
    vertexes[1][1] = 16'(y1);
    vertexes[2][0] = 16'(x2);
    vertexes[2][1] = 16'(y2);
    cull_mode      = cm;
  endtask

  // Present one triangle for a single edge, then advance two more edges
  task automatic launch(input int x0, input int y0, input int x1, input int y1,
                        input int x2, input int y2, input logic [1:0] cm);
    set_tri(x0, y0, x1, y1, x2, y2, cm);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    exp_in++;
    tick;
    tick;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", idle); end
    checks++; if ({cnt_in, cnt_out, cnt_culled} !== 48'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d/%0d want 0", cnt_in, cnt_out, cnt_culled); end
    checks++; if ({area2, edge_c, bbox_xmax, bbox_ymax} !== '0) begin errors++; $display("FAIL reset_data got area2=%0d xmax=%0d want 0", area2, bbox_xmax); end
    tick;
    tick;
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    int ea[3], eb[3];
    longint ec[3];
    ea = '{0, -10, 10};
    eb = '{10, -10, 0};
    ec = '{0, 100, 0};
    out_ready = 1'b1;
    launch(0, 0, 10, 0, 0, 10, 2'd0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL basic_busy_idle got %b want 0", idle); end
    tick;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got out_valid=%b want 1", out_valid); end
    for (int i = 0; i < 3; i++) begin
      checks++; if ($signed(edge_a[i]) !== ea[i]) begin errors++; $display("FAIL basic_a%0d got %0d want %0d", i, $signed(edge_a[i]), ea[i]); end
      checks++; if ($signed(edge_b[i]) !== eb[i]) begin errors++; $display("FAIL basic_b%0d got %0d want %0d", i, $signed(edge_b[i]), eb[i]); end
      checks++; if ($signed(edge_c[i]) !== ec[i]) begin errors++; $display("FAIL basic_c%0d got %0d want %0d", i, $signed(edge_c[i]), ec[i]); end
    end
    checks++; if (area2 !== 35'd100) begin errors++; $display("FAIL basic_area2 got %0d want 100", area2); end
    checks++; if ({bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax} !== {16'd0, 16'd10, 16'd0, 16'd10})
      begin errors++; $display("FAIL basic_bbox got %0d..%0d x %0d..%0d want 0..10 x 0..10", bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax); end
    tick;
    exp_out++;
    checks++; if (cnt_in !== 16'(exp_in) || cnt_out !== 16'(exp_out)) begin errors++; $display("FAIL basic_counts got in=%0d out=%0d want %0d/%0d", cnt_in, cnt_out, exp_in, exp_out); end
    checks++; if (out_valid !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL basic_drain got valid=%b idle=%b want 0/1", out_valid, idle); end
  endtask

  task automatic test_winding;
    int ea[3], eb[3];
    longint ec[3];
    // raw A=(-10,10,0) B=(0,10,-10) C=(0,-100,0), area -100 -> all negated
    ea = '{10, -10, 0};
    eb = '{0, -10, 10};
    ec = '{0, 100, 0};
    launch(0, 0, 0, 10, 10, 0, 2'd0);
    tick;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cw_valid got %b want 1", out_valid); end
    checks++; if (area2 !== 35'd100) begin errors++; $display("FAIL cw_area2 got %0d want 100", area2); end
    for (int i = 0; i < 3; i++) begin
      checks++; if ($signed(edge_a[i]) !== ea[i]) begin errors++; $display("FAIL cw_a%0d got %0d want %0d", i, $signed(edge_a[i]), ea[i]); end
      checks++; if ($signed(edge_b[i]) !== eb[i]) begin errors++; $display("FAIL cw_b%0d got %0d want %0d", i, $signed(edge_b[i]), eb[i]); end
      checks++; if ($signed(edge_c[i]) !== ec[i]) begin errors++; $display("FAIL cw_c%0d got %0d want %0d", i, $signed(edge_c[i]), ec[i]); end
    end
    tick;
    exp_out++;
    launch(0, 0, 0, 10, 10, 0, 2'd1);
    tick;
    exp_cull++;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cw_cull_valid got %b want 0", out_valid); end
    checks++; if (cnt_culled !== 16'(exp_cull)) begin errors++; $display("FAIL cw_cull_count got %0d want %0d", cnt_culled, exp_cull); end
    checks++; if (area2 !== 35'd100 || $signed(edge_a[0]) !== 10) begin errors++; $display("FAIL cw_cull_hold got area2=%0d a0=%0d want 100/10", area2, $signed(edge_a[0])); end
  endtask

  task automatic test_reject;
    launch(1, 1, 2, 2, 3, 3, 2'd0);
    tick;
    exp_cull++;
    checks++; if (out_valid !== 1'b0 || cnt_culled !== 16'(exp_cull)) begin errors++; $display("FAIL degenerate got valid=%b culled=%0d want 0/%0d", out_valid, cnt_culled, exp_cull); end
    launch(-30, 0, -10, 0, -20, 5, 2'd0);
    tick;
    exp_cull++;
    checks++; if (out_valid !== 1'b0 || cnt_culled !== 16'(exp_cull)) begin errors++; $display("FAIL offscreen_left got valid=%b culled=%0d want 0/%0d", out_valid, cnt_culled, exp_cull); end
    launch(800, 0, 900, 0, 800, 10, 2'd0);
    tick;
    exp_cull++;
    checks++; if (out_valid !== 1'b0 || cnt_culled !== 16'(exp_cull)) begin errors++; $display("FAIL offscreen_x800 got valid=%b culled=%0d want 0/%0d", out_valid, cnt_culled, exp_cull); end
    launch(0, 600, 10, 600, 0, 610, 2'd0);
    tick;
    exp_cull++;
    checks++; if (out_valid !== 1'b0 || cnt_culled !== 16'(exp_cull)) begin errors++; $display("FAIL offscreen_y600 got valid=%b culled=%0d want 0/%0d", out_valid, cnt_culled, exp_cull); end
    launch(0, 0, 10, 0, 0, 10, 2'd2);
    tick;
    exp_cull++;
    checks++; if (out_valid !== 1'b0 || cnt_culled !== 16'(exp_cull)) begin errors++; $display("FAIL cull_ccw got valid=%b culled=%0d want 0/%0d", out_valid, cnt_culled, exp_cull); end
    launch(0, 0, 10, 0, 0, 10, 2'd3);
    tick;
    checks++; if (out_valid !== 1'b1 || area2 !== 35'd100) begin errors++; $display("FAIL cull_mode3 got valid=%b area2=%0d want 1/100", out_valid, area2); end
    tick;
    exp_out++;
    // xmin on the last column is still on screen; area2 = 101*10
    launch(799, 0, 900, 0, 799, 10, 2'd0);
    tick;
    checks++; if (out_valid !== 1'b1 || area2 !== 35'd1010) begin errors++; $display("FAIL edge_col got valid=%b area2=%0d want 1/1010", out_valid, area2); end
    checks++; if (bbox_xmin !== 16'd799 || bbox_xmax !== 16'd799) begin errors++; $display("FAIL edge_col_bbox got %0d..%0d want 799..799", bbox_xmin, bbox_xmax); end
    tick;
    exp_out++;
  endtask

  task automatic test_clip;
    launch(-5, -5, 1000, -5, -5, 700, 2'd0);
    tick;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clip_valid got %b want 1", out_valid); end
    checks++; if ({bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax} !== {16'd0, 16'd799, 16'd0, 16'd599})
      begin errors++; $display("FAIL clip_bbox got %0d..%0d x %0d..%0d want 0..799 x 0..599", bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax); end
    checks++; if (area2 !== 35'd708525) begin errors++; $display("FAIL clip_area2 got %0d want 708525", area2); end
    tick;
    exp_out++;
    checks++; if (cnt_in !== 16'(exp_in) || cnt_out !== 16'(exp_out) || cnt_culled !== 16'(exp_cull))
      begin errors++; $display("FAIL running_counts got %0d/%0d/%0d want %0d/%0d/%0d", cnt_in, cnt_out, cnt_culled, exp_in, exp_out, exp_cull); end
  endtask

  task automatic test_back_to_back;
    int sent, recv, cyc, late;
    logic acc;
    stats_clr = 1'b1;
    tick;
    stats_clr = 1'b0;
    checks++; if ({cnt_in, cnt_out, cnt_culled} !== 48'd0) begin errors++; $display("FAIL stats_clr got %0d/%0d/%0d want 0", cnt_in, cnt_out, cnt_culled); end
    sent = 0; recv = 0; cyc = 0; acc = 1'b0;
    while (recv < 8 && cyc < 60) begin
      if (acc) sent++;
      if (sent < 8) begin
        set_tri(sent*3, 0, sent*3 + 10, 0, sent*3, 10, 2'd0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = !(cyc >= 6 && cyc < 10);
      #1;
      if (cyc >= 6 && cyc < 10) begin
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_cyc%0d got valid=%b in_ready=%b want 1/0", cyc, out_valid, in_ready); end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++; if (bbox_xmin !== 16'(recv*3)) begin errors++; $display("FAIL b2b_order%0d got xmin=%0d want %0d", recv, bbox_xmin, recv*3); end
        recv++;
      end
      acc = in_valid & in_ready;
      tick;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++; if (recv != 8) begin errors++; $display("FAIL b2b_timeout got %0d results want 8", recv); end
    late = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid === 1'b1) late++;
      tick;
    end
    checks++; if (late != 0) begin errors++; $display("FAIL b2b_duplicate got %0d extra results want 0", late); end
    checks++; if (cnt_out !== 16'd8 || cnt_in !== 16'd8) begin errors++; $display("FAIL b2b_counts got in=%0d out=%0d want 8/8", cnt_in, cnt_out); end
  endtask

  task automatic test_reset_inflight;
    int seen;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_tri(k, 0, k + 10, 0, k, 10, 2'd0);
      in_valid = 1'b1;
      tick;
    end
    in_valid = 1'b0;
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL inflight_idle got %b want 0", idle); end
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL flush_state got valid=%b idle=%b want 0/1", out_valid, idle); end
    checks++; if ({cnt_in, cnt_out, cnt_culled} !== 48'd0) begin errors++; $display("FAIL flush_counts got %0d/%0d/%0d want 0", cnt_in, cnt_out, cnt_culled); end
    tick;
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0 || idle !== 1'b1) begin errors++; $display("FAIL flush_stale got %0d outputs idle=%b want 0/1", seen, idle); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_winding;
    test_reject;
    test_clip;
    test_back_to_back;
    test_reset_inflight;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
